// File: rtl/wireout_capture.sv
// -----------------------------------------------------------------------------
// wireout_capture
//   Frame-based sample capture into a first-word-fall-through FIFO that a host
//   drains one word per ep_read strobe. A frame starts on cap_start and stores
//   cap_len din_valid samples. A status word reports the FIFO state, the sticky
//   error flags and the FSM state.
//
//   Handshake: a sample is offered on every cycle in which din_valid is high.
//   It is accepted only in CAPTURE and only if the FIFO has room, or a pop
//   happens in the same cycle. A word is popped on every cycle in which
//   ep_read is high and the FIFO is non-empty. There is no back-pressure. A
//   write that cannot be accepted sets overflow, and a read of an empty FIFO
//   sets underflow.
//
// Ports
//   ti_clk     in   clock, rising edge
//   reset_n    in   synchronous active-low reset
//   cap_start  in   frame start pulse
//   cap_len    in   [15:0] samples per frame (0 = empty frame)
//   din        in   [DATA_W-1:0] sample data
//   din_valid  in   sample qualifier
//   ep_read    in   host pop strobe
//   ep_datain  out  [DATA_W-1:0] FIFO head word (0 when empty)
//   flag_clr   in   clear the sticky overflow and underflow flags
//   status     out  [15:0] {2'b0, state, udf, ovf, full, empty, fill[7:0]}
//   busy       out  FSM in CAPTURE
//   done       out  FSM in DONE
// -----------------------------------------------------------------------------
module wireout_capture #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic              ti_clk,
  input  logic              reset_n,
  input  logic              cap_start,
  input  logic [15:0]       cap_len,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic              ep_read,
  output logic [DATA_W-1:0] ep_datain,
  input  logic              flag_clr,
  output logic [15:0]       status,
  output logic              busy,
  output logic              done
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_CAPTURE = 2'b01;
  localparam logic [1:0] ST_DONE    = 2'b10;

  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   FILL_ONE = 1;
  localparam logic [AW:0]   FILL_MAX = DEPTH;

  logic [1:0]        r_state;
  logic [15:0]       r_len;
  logic [15:0]       r_cnt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [AW:0]       r_fill;
  logic              r_ovf;
  logic              r_udf;

  logic w_empty, w_full, w_wr_req, w_wr, w_rd, w_ovf_set, w_udf_set;
  logic [7:0] w_fill8;

  assign w_empty   = (r_fill == '0);
  assign w_full    = (r_fill == FILL_MAX);
  assign w_wr_req  = (r_state == ST_CAPTURE) && din_valid;
  assign w_rd      = ep_read && !w_empty;
  // When the FIFO is full, a simultaneous pop makes room for the write.
  assign w_wr      = w_wr_req && (!w_full || ep_read);
  assign w_ovf_set = w_wr_req && w_full && !ep_read;
  assign w_udf_set = ep_read && w_empty;
  assign w_fill8   = 8'(r_fill);

  // FSM and frame sample counter
  always_ff @(posedge ti_clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_len   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_CAPTURE: begin
          // Every valid cycle counts toward the frame, even a dropped sample.
          if (din_valid) begin
            r_cnt <= r_cnt + 16'd1;
            if (r_cnt == r_len - 16'd1) r_state <= ST_DONE;
          end
        end
        ST_IDLE, ST_DONE: begin
          if (cap_start) begin
            if (cap_len != 16'd0) begin
              r_state <= ST_CAPTURE;
              r_len   <= cap_len;
              r_cnt   <= '0;
            end else begin
              r_state <= ST_DONE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // FIFO storage: no reset is needed because the pointers and fill count guard it.
  always_ff @(posedge ti_clk) begin
    if (reset_n && w_wr) r_mem[r_wptr] <= din;
  end

  // FIFO pointers, fill count and sticky flags
  always_ff @(posedge ti_clk) begin
    if (!reset_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fill <= '0;
      r_ovf  <= 1'b0;
      r_udf  <= 1'b0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + PTR_ONE;
      if (w_rd) r_rptr <= r_rptr + PTR_ONE;
      case ({w_wr, w_rd})
        2'b10:   r_fill <= r_fill + FILL_ONE;
        2'b01:   r_fill <= r_fill - FILL_ONE;
        default: r_fill <= r_fill;
      endcase
      // A set event in the same cycle takes precedence over the clear.
      if (w_ovf_set)     r_ovf <= 1'b1;
      else if (flag_clr) r_ovf <= 1'b0;
      if (w_udf_set)     r_udf <= 1'b1;
      else if (flag_clr) r_udf <= 1'b0;
    end
  end

  assign ep_datain = w_empty ? '0 : r_mem[r_rptr];
  assign status    = {2'b00, r_state, r_udf, r_ovf, w_full, w_empty, w_fill8};
  assign busy      = (r_state == ST_CAPTURE);
  assign done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_wireout_capture.sv
// -----------------------------------------------------------------------------
// tb_wireout_capture
//   Drives wireout_capture and compares its outputs with a queue-based model
//   of the frame/FIFO behaviour. The bench also checks the directed scenarios
//   against fixed expected values.
// -----------------------------------------------------------------------------
module tb_wireout_capture;

  localparam int DEPTH = 16;

  logic        ti_clk;
  logic        reset_n;
  logic        cap_start;
  logic [15:0] cap_len;
  logic [15:0] din;
  logic        din_valid;
  logic        ep_read;
  logic [15:0] ep_datain;
  logic        flag_clr;
  logic [15:0] status;
  logic        busy;
  logic        done;

  int n_vec = 0;
  int n_err = 0;

  wireout_capture #(.DATA_W(16), .DEPTH(DEPTH)) dut (
    .ti_clk    (ti_clk),
    .reset_n   (reset_n),
    .cap_start (cap_start),
    .cap_len   (cap_len),
    .din       (din),
    .din_valid (din_valid),
    .ep_read   (ep_read),
    .ep_datain (ep_datain),
    .flag_clr  (flag_clr),
    .status    (status),
    .busy      (busy),
    .done      (done)
  );

  // ---------------- clock ----------------
  initial begin
    ti_clk = 1'b0;
    forever #5 ti_clk = ~ti_clk;
  end

  // ---------------- reference model ----------------
  logic [15:0] m_q[$];
  logic        m_ovf, m_udf;
  logic [1:0]  m_mode;   // 0 idle, 1 capture, 2 done
  int          m_left;   // samples still owed to the current frame

  task automatic m_step();
    int sz;
    bit wr_req, rd, wr;
    if (!reset_n) begin
      m_q.delete();
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
      m_mode = 2'd0;
      m_left = 0;
      return;
    end
    sz     = m_q.size();
    wr_req = (m_mode == 2'd1) && din_valid;
    rd     = ep_read && (sz > 0);
    wr     = wr_req && ((sz < DEPTH) || ep_read);
    if (flag_clr) begin
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end
    if (wr_req && sz == DEPTH && !ep_read) m_ovf = 1'b1;
    if (ep_read && sz == 0) m_udf = 1'b1;
    if (rd) void'(m_q.pop_front());
    if (wr) m_q.push_back(din);
    if (m_mode == 2'd1) begin
      if (din_valid) begin
        m_left--;
        if (m_left == 0) m_mode = 2'd2;
      end
    end else if (cap_start) begin
      if (cap_len != 16'd0) begin
        m_mode = 2'd1;
        m_left = int'(cap_len);
      end else begin
        m_mode = 2'd2;
      end
    end
  endtask

  function automatic logic [33:0] m_obs();
    int sz;
    logic [15:0] st, hd;
    sz = m_q.size();
    hd = (sz > 0) ? m_q[0] : 16'h0000;
    st = {2'b00, m_mode, m_udf, m_ovf, (sz == DEPTH), (sz == 0), 8'(sz)};
    return {st, hd, (m_mode == 2'd1), (m_mode == 2'd2)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    cap_start = 1'b0;
    cap_len   = 16'd0;
    din       = 16'd0;
    din_valid = 1'b0;
    ep_read   = 1'b0;
    flag_clr  = 1'b0;
  endtask

  // One clock: the model consumes the inputs held across the edge, and
  // outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge ti_clk);
    m_step();
    #1;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic start_frame(input logic [15:0] len);
    cap_len   = len;
    cap_start = 1'b1;
    tick();
    cap_start = 1'b0;
  endtask

  task automatic push_sample(input logic [15:0] d);
    din       = d;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic pop_word();
    ep_read = 1'b1;
    tick();
    ep_read = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    n_vec++;
    if ({status, ep_datain, busy, done} !== {16'h0100, 16'h0000, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state act=%h/%h/%b/%b exp=0100/0000/0/0", status, ep_datain, busy, done);
    end
    reset_n = 1'b1;
    tick();
    n_vec++;
    if ({status, ep_datain, busy, done} !== m_obs()) begin
      n_err++;
      $display("FAIL reset_release act=%h exp=%h", {status, ep_datain, busy, done}, m_obs());
    end
  endtask

  task automatic test_basic(input bit do_rst);
    logic [15:0] exp;
    if (do_rst) pulse_reset();
    start_frame(16'd4);
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL basic_busy act=%b exp=1", busy);
    end
    for (int i = 0; i < 4; i++) begin
      exp = 16'(16'h0011 * (i + 1));
      push_sample(exp);
    end
    n_vec++;
    if ({done, status[7:0], ep_datain} !== {1'b1, 8'd4, 16'h0011}) begin
      n_err++;
      $display("FAIL basic_done act=%b/%0d/%h exp=1/4/0011", done, status[7:0], ep_datain);
    end
    for (int i = 0; i < 4; i++) begin
      exp = 16'(16'h0011 * (i + 1));
      n_vec++;
      if (ep_datain !== exp) begin
        n_err++;
        $display("FAIL basic_read%0d act=%h exp=%h", i, ep_datain, exp);
      end
      pop_word();
    end
    n_vec++;
    if (status[8] !== 1'b1 || {status, ep_datain, busy, done} !== m_obs()) begin
      n_err++;
      $display("FAIL basic_empty act=%h exp=%h", {status, ep_datain, busy, done}, m_obs());
    end
  endtask

  task automatic test_overflow();
    logic [15:0] smp [20];
    pulse_reset();
    start_frame(16'd20);
    for (int i = 0; i < 20; i++) begin
      smp[i] = 16'($urandom);
      push_sample(smp[i]);
    end
    n_vec++;
    if ({status[9], status[10], status[7:0], done} !== {1'b1, 1'b1, 8'd16, 1'b1}) begin
      n_err++;
      $display("FAIL ovf_flags act=full%b ovf%b cnt%0d done%b exp=1 1 16 1",
               status[9], status[10], status[7:0], done);
    end
    for (int i = 0; i < 16; i++) begin
      n_vec++;
      if (ep_datain !== smp[i]) begin
        n_err++;
        $display("FAIL ovf_read%0d act=%h exp=%h", i, ep_datain, smp[i]);
      end
      pop_word();
    end
    n_vec++;
    if ({status, ep_datain, busy, done} !== m_obs()) begin
      n_err++;
      $display("FAIL ovf_drained act=%h exp=%h", {status, ep_datain, busy, done}, m_obs());
    end
  endtask

  task automatic test_full_rw();
    logic [15:0] smp [17];
    pulse_reset();
    start_frame(16'd17);
    for (int i = 0; i < 16; i++) begin
      smp[i] = 16'($urandom);
      push_sample(smp[i]);
    end
    n_vec++;
    if ({status[9], status[10], status[7:0], busy} !== {1'b1, 1'b0, 8'd16, 1'b1}) begin
      n_err++;
      $display("FAIL fullrw_pre act=full%b ovf%b cnt%0d busy%b exp=1 0 16 1",
               status[9], status[10], status[7:0], busy);
    end
    smp[16]   = 16'($urandom);
    din       = smp[16];
    din_valid = 1'b1;
    ep_read   = 1'b1;
    tick();
    din_valid = 1'b0;
    ep_read   = 1'b0;
    n_vec++;
    if ({status[7:0], status[10], done, ep_datain} !== {8'd16, 1'b0, 1'b1, smp[1]}) begin
      n_err++;
      $display("FAIL fullrw_post act=cnt%0d ovf%b done%b head%h exp=16 0 1 %h",
               status[7:0], status[10], done, ep_datain, smp[1]);
    end
    for (int i = 1; i < 17; i++) begin
      n_vec++;
      if (ep_datain !== smp[i]) begin
        n_err++;
        $display("FAIL fullrw_read%0d act=%h exp=%h", i, ep_datain, smp[i]);
      end
      pop_word();
    end
  endtask

  task automatic test_underflow();
    pulse_reset();
    pop_word();
    n_vec++;
    if ({status[11], status[7:0]} !== {1'b1, 8'd0}) begin
      n_err++;
      $display("FAIL udf_set act=udf%b cnt%0d exp=1 0", status[11], status[7:0]);
    end
    ep_read  = 1'b1;
    flag_clr = 1'b1;
    tick();
    ep_read  = 1'b0;
    n_vec++;
    if (status[11] !== 1'b1) begin
      n_err++;
      $display("FAIL udf_set_wins act=%b exp=1", status[11]);
    end
    tick();
    flag_clr = 1'b0;
    n_vec++;
    if (status[11] !== 1'b0 || {status, ep_datain, busy, done} !== m_obs()) begin
      n_err++;
      $display("FAIL udf_clear act=%h exp=%h", {status, ep_datain, busy, done}, m_obs());
    end
  endtask

  task automatic test_zero_len_and_ignore();
    pulse_reset();
    start_frame(16'd0);
    n_vec++;
    if ({done, status[13:12], status[7:0]} !== {1'b1, 2'b10, 8'd0}) begin
      n_err++;
      $display("FAIL zero_len act=done%b st%b cnt%0d exp=1 10 0", done, status[13:12], status[7:0]);
    end
    start_frame(16'd3);
    cap_start = 1'b1;
    cap_len   = 16'd9;
    push_sample(16'hA001);
    cap_start = 1'b0;
    push_sample(16'hA002);
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL ignore_busy act=%b exp=1", busy);
    end
    push_sample(16'hA003);
    n_vec++;
    if ({done, status[7:0], ep_datain} !== {1'b1, 8'd3, 16'hA001}) begin
      n_err++;
      $display("FAIL ignore_len act=done%b cnt%0d head%h exp=1 3 a001", done, status[7:0], ep_datain);
    end
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    start_frame(16'd8);
    for (int i = 0; i < 3; i++) push_sample(16'(16'hB000 + i));
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    n_vec++;
    if ({status[13:12], status[7:0], ep_datain, busy} !== {2'b00, 8'd0, 16'h0000, 1'b0}) begin
      n_err++;
      $display("FAIL reset_mid act=st%b cnt%0d head%h busy%b exp=00 0 0000 0",
               status[13:12], status[7:0], ep_datain, busy);
    end
    test_basic(1'b0);
  endtask

  task automatic test_random();
    pulse_reset();
    for (int c = 0; c < 800; c++) begin
      reset_n   = ($urandom_range(0, 299) != 0);
      cap_start = ($urandom_range(0, 7) == 0);
      cap_len   = 16'($urandom_range(0, 24));
      din       = 16'($urandom);
      din_valid = ($urandom_range(0, 1) == 1);
      ep_read   = (c < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      flag_clr  = ($urandom_range(0, 15) == 0);
      tick();
      n_vec++;
      if ({status, ep_datain, busy, done} !== m_obs()) begin
        n_err++;
        $display("FAIL random_c%0d act=%h exp=%h", c, {status, ep_datain, busy, done}, m_obs());
      end
    end
    reset_n = 1'b1;
    clear_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset_n = 1'b0;
    clear_inputs();
    m_q.delete();
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    m_mode = 2'd0;
    m_left = 0;
    test_reset();
    test_basic(1'b1);
    test_overflow();
    test_full_rw();
    test_underflow();
    test_zero_len_and_ignore();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
